// File: rtl/mobius_iter_if.sv
// Handshake bundle for the Mobius transform block: input vector channel
// and result channel, each valid/ready.
interface mobius_iter_if #(
   parameter int N = 64
) ();
   logic         in_valid;
   logic         in_ready;
   logic [0:N-1] in_data;
   logic         in_dir;
   logic         out_valid;
   logic         out_ready;
   logic [0:N-1] out_data;

   // Producer/consumer side (drives vectors in, takes results out)
   modport master (
      output in_valid, in_data, in_dir, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Transform block side
   modport slave (
      input  in_valid, in_data, in_dir, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/mobius_iter.sv
// Iterative GF(2) Mobius (subset/superset) transform. One vector at a time:
// load in IDLE, apply SPC butterfly stages per clock in RUN, hold in DONE
// until the consumer takes the result.
module mobius_iter #(
   parameter int N      = 64,
   parameter int LOG2_N = 6,
   parameter int SPC    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   mobius_iter_if.slave  bus,
   output logic          busy
);
   localparam int K  = LOG2_N / SPC;
   localparam int CW = $clog2(K + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [0:N-1]  data_q, data_d;
   logic          dir_q, dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [0:N-1]  staged;

   // One butterfly stage s. Pairs (i, i+half) are disjoint, so every update
   // reads the stage input d and writes only into r.
   function automatic logic [0:N-1] bfly(input logic [0:N-1] d, input int s,
                                         input logic dir);
      logic [0:N-1] r;
      int           half;
      r    = d;
      half = N >> (s + 1);
      for (int i = 0; i < N; i++) begin
         if (!dir && ((i & half) != 0))
            r[i] = d[i] ^ d[i - half];
         else if (dir && ((i & half) == 0))
            r[i] = d[i] ^ d[i + half];
      end
      return r;
   endfunction

   // Chain the SPC stages belonging to group cnt_q; stage index is resolved
   // against every constant s so each butterfly is fixed wiring plus a mux.
   always_comb begin
      staged = data_q;
      for (int t = 0; t < SPC; t++) begin
         for (int s = 0; s < LOG2_N; s++) begin
            if (s == int'(cnt_q) * SPC + t)
               staged = bfly(staged, s, dir_q);
         end
      end
   end

   // Next-state: accept in IDLE, iterate in RUN, hand off in DONE
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               data_d  = bus.in_data;
               dir_d   = bus.in_dir;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            data_d = staged;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(K - 1))
               state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything, aborting any vector
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake outputs depend on state only, so no valid->ready paths exist
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = data_q;
   assign busy          = (state_q == RUN);
endmodule

// File: tb/tb_mobius_iter.sv
// Directed bench: N=8 block for hand-checked vectors, handshake and reset
// cases; four N=64 blocks (SPC 1/2/3/6) against a direct subset-sum model.
module tb_mobius_iter;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // N=8, SPC=1 instance
   mobius_iter_if #(.N(8)) b8 ();
   logic busy8;
   mobius_iter #(.N(8), .LOG2_N(3), .SPC(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(b8), .busy(busy8));

   // N=64 instances sharing one input stream
   logic        v64;
   logic [0:63] d64;
   logic        dir64;
   logic [3:0]  o_valid, o_rdy, o_busy;
   logic [0:63] o_data [4];

   for (genvar g = 0; g < 4; g++) begin : g64
      localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
      mobius_iter_if #(.N(64)) bif ();
      logic bsy;
      assign bif.in_valid  = v64;
      assign bif.in_data   = d64;
      assign bif.in_dir    = dir64;
      assign bif.out_ready = 1'b1;
      assign o_valid[g]    = bif.out_valid;
      assign o_rdy[g]      = bif.in_ready;
      assign o_data[g]     = bif.out_data;
      assign o_busy[g]     = bsy;
      mobius_iter #(.N(64), .LOG2_N(6), .SPC(S)) dut (
         .clk(clk), .rst_n(rst_n), .bus(bif), .busy(bsy));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Direct definition of the transform, independent of butterfly ordering
   function automatic logic [0:63] ref64(input logic [0:63] x, input logic dir);
      logic [0:63] r;
      r = '0;
      for (int i = 0; i < 64; i++)
         for (int j = 0; j < 64; j++)
            if (dir ? ((i & ~j) == 0) : ((j & ~i) == 0))
               r[i] = r[i] ^ x[j];
      return r;
   endfunction

   // Push one vector into the N=8 block; report result and out_valid cycle
   task automatic run8(input logic [0:7] din, input logic dir,
                       output logic [0:7] res, output int lat);
      b8.in_data  = din;
      b8.in_dir   = dir;
      b8.in_valid = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      lat = -1;
      res = 'x;
      for (int c = 1; c <= 20; c++) begin
         if (b8.out_valid) begin
            lat = c;
            res = b8.out_data;
            break;
         end
         tick();
      end
      if (lat > 0) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({b8.in_ready, b8.out_valid, busy8} !== 3'b100) begin
         failures++;
         $display("FAIL reset_ctl8 got=%b exp=100", {b8.in_ready, b8.out_valid, busy8});
      end
      checks++;
      if (b8.out_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_data8 got=%h exp=00", b8.out_data);
      end
      checks++;
      if (o_rdy !== 4'hf || o_valid !== 4'h0 || o_busy !== 4'h0) begin
         failures++;
         $display("FAIL reset_ctl64 got=%h%h%h exp=f00", o_rdy, o_valid, o_busy);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({b8.in_ready, b8.out_valid, busy8} !== 3'b100 || b8.out_data !== 8'h00) begin
         failures++;
         $display("FAIL post_reset got=%b/%h exp=100/00",
                  {b8.in_ready, b8.out_valid, busy8}, b8.out_data);
      end
   endtask

   task automatic test_basic8();
      logic [0:7] r;
      int         lat;
      run8(8'b10000000, 1'b0, r, lat);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL lat8 got=%0d exp=4", lat);
      end
      checks++;
      if (r !== 8'b11111111) begin
         failures++;
         $display("FAIL sub_80 got=%b exp=11111111", r);
      end
      run8(8'b10000000, 1'b1, r, lat);
      checks++;
      if (r !== 8'b10000000) begin
         failures++;
         $display("FAIL sup_80 got=%b exp=10000000", r);
      end
      run8(8'b00000001, 1'b1, r, lat);
      checks++;
      if (r !== 8'b11111111) begin
         failures++;
         $display("FAIL sup_01 got=%b exp=11111111", r);
      end
      run8(8'b00000001, 1'b0, r, lat);
      checks++;
      if (r !== 8'b00000001) begin
         failures++;
         $display("FAIL sub_01 got=%b exp=00000001", r);
      end
   endtask

   task automatic test_involution();
      logic [0:7] r, r2;
      int         lat;
      run8(8'b10110010, 1'b0, r, lat);
      checks++;
      if (r !== 8'b11011110) begin
         failures++;
         $display("FAIL sub_b2 got=%b exp=11011110", r);
      end
      run8(r, 1'b0, r2, lat);
      checks++;
      if (r2 !== 8'b10110010) begin
         failures++;
         $display("FAIL invol got=%b exp=10110010", r2);
      end
   endtask

   task automatic test_random64();
      logic [0:63] vec [6];
      logic [0:63] res [4];
      int          lat [4];
      int          expl [4];
      logic [0:63] e;
      expl = '{7, 4, 3, 2};
      vec[0] = {1'b1, 63'b0};
      vec[1] = {63'b0, 1'b1};
      vec[2] = '1;
      for (int v = 3; v < 6; v++) vec[v] = {$urandom(), $urandom()};
      for (int v = 0; v < 6; v++) begin
         for (int dir = 0; dir < 2; dir++) begin
            d64   = vec[v];
            dir64 = dir[0];
            v64   = 1'b1;
            tick();
            v64 = 1'b0;
            for (int g = 0; g < 4; g++) begin
               lat[g] = -1;
               res[g] = 'x;
            end
            for (int c = 1; c <= 10; c++) begin
               for (int g = 0; g < 4; g++)
                  if (o_valid[g] && lat[g] < 0) begin
                     lat[g] = c;
                     res[g] = o_data[g];
                  end
               tick();
            end
            e = ref64(vec[v], dir[0]);
            for (int g = 0; g < 4; g++) begin
               checks++;
               if (lat[g] !== expl[g] || res[g] !== e) begin
                  failures++;
                  $display("FAIL rand64 inst=%0d vec=%0d dir=%0d got=%h@%0d exp=%h@%0d",
                           g, v, dir, res[g], lat[g], e, expl[g]);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int ok;
      b8.out_ready = 1'b0;
      b8.in_data   = 8'b10000000;
      b8.in_dir    = 1'b0;
      b8.in_valid  = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      ok = 0;
      for (int c = 1; c <= 10 && !ok; c++) begin
         if (b8.out_valid) ok = 1;
         else tick();
      end
      checks++;
      if (!ok || b8.out_data !== 8'hff) begin
         failures++;
         $display("FAIL bp_first got=%h valid=%0d exp=ff", b8.out_data, ok);
      end
      for (int k = 0; k < 5; k++) begin
         b8.in_valid = (k == 1 || k == 3);
         b8.in_data  = 8'h55;
         b8.in_dir   = 1'b1;
         tick();
         checks++;
         if (b8.out_valid !== 1'b1 || b8.in_ready !== 1'b0 || b8.out_data !== 8'hff) begin
            failures++;
            $display("FAIL bp_hold k=%0d got=v%b r%b %h exp=v1 r0 ff",
                     k, b8.out_valid, b8.in_ready, b8.out_data);
         end
      end
      b8.in_valid  = 1'b0;
      b8.out_ready = 1'b1;
      tick();
      checks++;
      if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.out_data !== 8'hff) begin
         failures++;
         $display("FAIL bp_release got=v%b r%b %h exp=v0 r1 ff",
                  b8.out_valid, b8.in_ready, b8.out_data);
      end
      tick();
      checks++;
      if (busy8 !== 1'b0 || b8.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_ignored got=busy%b v%b exp=busy0 v0", busy8, b8.out_valid);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [0:7] r;
      int         lat;
      int         seen;
      b8.in_data  = 8'b10110010;
      b8.in_dir   = 1'b0;
      b8.in_valid = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      tick();
      checks++;
      if (busy8 !== 1'b1) begin
         failures++;
         $display("FAIL mid_busy got=%b exp=1", busy8);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (b8.out_data !== 8'h00 || b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 ||
          busy8 !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got=%h r%b v%b b%b exp=00 r1 v0 b0",
                  b8.out_data, b8.in_ready, b8.out_valid, busy8);
      end
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (b8.out_valid) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL abort_valid got=%0d exp=0", seen);
      end
      run8(8'b00000001, 1'b1, r, lat);
      checks++;
      if (r !== 8'b11111111 || lat !== 4) begin
         failures++;
         $display("FAIL after_abort got=%b@%0d exp=11111111@4", r, lat);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      b8.in_valid  = 1'b0;
      b8.in_data   = '0;
      b8.in_dir    = 1'b0;
      b8.out_ready = 1'b1;
      v64          = 1'b0;
      d64          = '0;
      dir64        = 1'b0;
      test_reset();
      test_basic8();
      test_involution();
      test_random64();
      test_backpressure();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
